// File: rtl/hyper_dev_resp_if.sv
// HyperBus-style word bus plus single-port memory interface of the device responder.
// No latency of its own: it only groups the device-side signals.
// No backpressure here; flow control lives in ck_en_i slots and the cs_ni framing.
interface hyper_dev_resp_if #(
    parameter int AddrWidth = 16
) ();
    logic                 cs_ni;
    logic                 ck_en_i;
    logic [15:0]          dq_i;
    logic [1:0]           rwds_i;
    logic [15:0]          dq_o;
    logic                 dq_oe_o;
    logic                 rwds_o;
    logic                 rwds_oe_o;
    logic                 mem_req_o;
    logic                 mem_we_o;
    logic [AddrWidth-1:0] mem_addr_o;
    logic [15:0]          mem_wdata_o;
    logic [1:0]           mem_be_o;
    logic [15:0]          mem_rdata_i;

    modport slave (
        input  cs_ni, ck_en_i, dq_i, rwds_i, mem_rdata_i,
        output dq_o, dq_oe_o, rwds_o, rwds_oe_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

    modport master (
        output cs_ni, ck_en_i, dq_i, rwds_i, mem_rdata_i,
        input  dq_o, dq_oe_o, rwds_o, rwds_oe_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );
endinterface

// File: rtl/hyper_dev_resp.sv
// HyperBus-style device responder: CA decode, CR0 latency, burst reads/writes to a 1-cycle memory.
// Latency: CR0-programmed slots before data; reads stream one word per slot (mem data bypassed).
// Backpressure: controller paces via ck_en_i, rwds_o marks valid read data; HYPER_DEV_RESP_WRAP_EN enables wrapped bursts.
module hyper_dev_resp #(
    parameter int AddrWidth  = 16,
    parameter int RstLatency = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    hyper_dev_resp_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        CMD_ADDR,
        LATENCY,
        READ,
        WRITE,
        REG_WRITE,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          ca_hi_q, ca_hi_d;
    logic [1:0]           ca_cnt_q, ca_cnt_d;
    logic [4:0]           lat_cnt_q, lat_cnt_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [15:0]          dq_q, dq_d;
    logic                 dq_vld_q, dq_vld_d;
    logic                 rd_pend_q, rd_pend_d;
    logic                 is_read_q, is_read_d;
    logic                 is_reg_q, is_reg_d;
    logic [3:0]           cr0_lat_q, cr0_lat_d;
    logic                 cr0_fix_q, cr0_fix_d;
`ifdef HYPER_DEV_RESP_WRAP_EN
    logic                 is_lin_q, is_lin_d;
`endif

    logic                 active;
    logic                 slot;
    logic                 rd_issue;
    logic                 word_vld;
    logic [15:0]          word;
    logic [4:0]           lat_slots;
    logic [31:0]          start_full;
    logic [AddrWidth-1:0] start_addr;
    logic [AddrWidth-1:0] addr_nxt;
    logic [15:0]          reg_rd;
    logic                 unused_ca;

    logic                 mem_req;
    logic                 mem_we;
    logic [AddrWidth-1:0] mem_addr;
    logic [15:0]          mem_wdata;
    logic [1:0]           mem_be;

    // Reset acts like a deselect so nothing is issued in the reset cycle itself.
    assign active     = rst_ni & ~bus.cs_ni;
    assign slot       = active & bus.ck_en_i;
    assign lat_slots  = cr0_fix_q ? {cr0_lat_q, 1'b0} : {1'b0, cr0_lat_q};
    assign start_full = {ca_hi_q[28:0], bus.dq_i[2:0]};
    assign start_addr = start_full[AddrWidth-1:0];
    assign reg_rd     = (addr_q == '0) ? {8'h00, cr0_lat_q, cr0_fix_q, 3'b000} : 16'h0C81;
    assign word_vld   = dq_vld_q | rd_pend_q;
    assign word       = rd_pend_q ? bus.mem_rdata_i : dq_q;
    assign unused_ca  = ^{ca_hi_q, start_full};

    always_comb begin
        addr_nxt = addr_q + AddrWidth'(1);
`ifdef HYPER_DEV_RESP_WRAP_EN
        if (!is_lin_q) begin
            addr_nxt = {addr_q[AddrWidth-1:4], addr_q[3:0] + 4'd1};
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        ca_hi_d   = ca_hi_q;
        ca_cnt_d  = ca_cnt_q;
        lat_cnt_d = lat_cnt_q;
        addr_d    = addr_q;
        dq_d      = dq_q;
        dq_vld_d  = dq_vld_q;
        rd_pend_d = 1'b0;
        is_read_d = is_read_q;
        is_reg_d  = is_reg_q;
        cr0_lat_d = cr0_lat_q;
        cr0_fix_d = cr0_fix_q;
`ifdef HYPER_DEV_RESP_WRAP_EN
        is_lin_d  = is_lin_q;
`endif
        rd_issue  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;

        if (!active) begin
            state_d  = IDLE;
            dq_vld_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = CMD_ADDR;
                    ca_cnt_d = 2'd0;
                    dq_vld_d = 1'b0;
                end
                CMD_ADDR: begin
                    if (slot) begin
                        ca_cnt_d = ca_cnt_q + 2'd1;
                        if (ca_cnt_q == 2'd0) begin
                            ca_hi_d[31:16] = bus.dq_i;
                        end else if (ca_cnt_q == 2'd1) begin
                            ca_hi_d[15:0] = bus.dq_i;
                        end else begin
                            is_read_d = ca_hi_q[31];
                            is_reg_d  = ca_hi_q[30];
`ifdef HYPER_DEV_RESP_WRAP_EN
                            is_lin_d  = ca_hi_q[29];
`endif
                            addr_d    = start_addr;
                            if (!ca_hi_q[31] && ca_hi_q[30]) begin
                                state_d = REG_WRITE;
                            end else if (lat_slots == 5'd0) begin
                                state_d = ca_hi_q[31] ? READ : WRITE;
                            end else begin
                                state_d   = LATENCY;
                                lat_cnt_d = lat_slots;
                            end
                        end
                    end
                end
                LATENCY: begin
                    if (slot) begin
                        if (lat_cnt_q == 5'd1) begin
                            state_d  = is_read_q ? READ : WRITE;
                            rd_issue = is_read_q;
                        end else begin
                            lat_cnt_d = lat_cnt_q - 5'd1;
                        end
                    end
                end
                READ: begin
                    // A slot consumes the presented word and fetches the next one in the same cycle.
                    if (slot && word_vld) begin
                        dq_vld_d = 1'b0;
                        rd_issue = 1'b1;
                    end else if (rd_pend_q) begin
                        dq_d     = bus.mem_rdata_i;
                        dq_vld_d = 1'b1;
                    end else if (!dq_vld_q) begin
                        rd_issue = 1'b1;
                    end
                end
                WRITE: begin
                    if (slot) begin
                        mem_req   = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = addr_q;
                        mem_wdata = bus.dq_i;
                        mem_be    = ~bus.rwds_i;
                        addr_d    = addr_nxt;
                    end
                end
                REG_WRITE: begin
                    if (slot) begin
                        cr0_lat_d = bus.dq_i[7:4];
                        cr0_fix_d = bus.dq_i[3];
                        state_d   = DONE;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (rd_issue) begin
            addr_d = addr_nxt;
            if (is_reg_q) begin
                dq_d     = reg_rd;
                dq_vld_d = 1'b1;
            end else begin
                mem_req   = 1'b1;
                mem_addr  = addr_q;
                rd_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ca_hi_q   <= '0;
            ca_cnt_q  <= '0;
            lat_cnt_q <= '0;
            addr_q    <= '0;
            dq_q      <= '0;
            dq_vld_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            is_read_q <= 1'b0;
            is_reg_q  <= 1'b0;
            cr0_lat_q <= 4'(RstLatency);
            cr0_fix_q <= 1'b1;
`ifdef HYPER_DEV_RESP_WRAP_EN
            is_lin_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            ca_hi_q   <= ca_hi_d;
            ca_cnt_q  <= ca_cnt_d;
            lat_cnt_q <= lat_cnt_d;
            addr_q    <= addr_d;
            dq_q      <= dq_d;
            dq_vld_q  <= dq_vld_d;
            rd_pend_q <= rd_pend_d;
            is_read_q <= is_read_d;
            is_reg_q  <= is_reg_d;
            cr0_lat_q <= cr0_lat_d;
            cr0_fix_q <= cr0_fix_d;
`ifdef HYPER_DEV_RESP_WRAP_EN
            is_lin_q  <= is_lin_d;
`endif
        end
    end

    always_comb begin
        bus.dq_oe_o   = 1'b0;
        bus.dq_o      = '0;
        bus.rwds_oe_o = 1'b0;
        bus.rwds_o    = 1'b0;
        if (state_q == CMD_ADDR) begin
            bus.rwds_oe_o = 1'b1;
            bus.rwds_o    = cr0_fix_q;
        end else if (state_q == READ) begin
            bus.dq_oe_o   = 1'b1;
            bus.dq_o      = word;
            bus.rwds_oe_o = 1'b1;
            bus.rwds_o    = word_vld;
        end
    end

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.mem_be_o    = mem_be;

endmodule

// File: tb/tb_hyper_dev_resp.sv
module tb_hyper_dev_resp;
    localparam int AW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic [1:0]    be;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hyper_dev_resp_if #(.AddrWidth(AW)) bus ();

    hyper_dev_resp #(.AddrWidth(AW), .RstLatency(6)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    logic [15:0]   mem [0:255];
    logic [AW-1:0] exp_rd_q [$];
    logic [15:0]   exp_dat_q [$];
    wr_t           exp_wr_q [$];
    int            errors = 0;
    int            checks = 0;
    bit            pend_rd = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    logic [3:0]    lat_m = 4'd6;
    logic          fix_m = 1'b1;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a, input bit lin);
`ifdef HYPER_DEV_RESP_WRAP_EN
        if (!lin) return {a[AW-1:4], a[3:0] + 4'd1};
`endif
        return a + AW'(1);
    endfunction

    function automatic logic [15:0] reg_model(input logic [AW-1:0] a);
        return (a == '0) ? {8'h00, lat_m, fix_m, 3'b000} : 16'h0C81;
    endfunction

    function automatic int lat_slots_m();
        return int'(lat_m) * (fix_m ? 2 : 1);
    endfunction

    function automatic logic [47:0] make_ca(input bit rd, input bit rs, input bit lin, input logic [31:0] a);
        return {rd, rs, lin, a[31:3], 13'd0, a[2:0]};
    endfunction

    // One bus cycle: drive at negedge, then score any memory request and any read word taken.
    task automatic cycle(input bit cs, input bit ck, input logic [15:0] dq, input logic [1:0] rwds,
                         output bit took);
        wr_t           e;
        logic [AW-1:0] ea;
        logic [15:0]   ed;
        @(negedge clk);
        bus.mem_rdata_i = pend_rd ? mem[pend_addr[7:0]] : 16'hDEAD;
        pend_rd     = 1'b0;
        bus.cs_ni   = cs;
        bus.ck_en_i = ck;
        bus.dq_i    = dq;
        bus.rwds_i  = rwds;
        #1;
        took = 1'b0;
        if (bus.mem_req_o === 1'b1) begin
            checks++;
            if (bus.mem_we_o === 1'b1) begin
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%h data=%h be=%b", bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o);
                end else begin
                    e = exp_wr_q.pop_front();
                    if ({bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o} !== e)
                        begin
                            errors++;
                            $display("FAIL write_req got addr=%h data=%h be=%b want addr=%h data=%h be=%b",
                                     bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o, e.addr, e.data, e.be);
                        end
                end
                if (bus.mem_be_o[0] === 1'b1) mem[bus.mem_addr_o[7:0]][7:0]  = bus.mem_wdata_o[7:0];
                if (bus.mem_be_o[1] === 1'b1) mem[bus.mem_addr_o[7:0]][15:8] = bus.mem_wdata_o[15:8];
            end else begin
                if (exp_rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read addr=%h", bus.mem_addr_o);
                end else begin
                    ea = exp_rd_q.pop_front();
                    if (bus.mem_addr_o !== ea) begin
                        errors++;
                        $display("FAIL read_addr got %h want %h", bus.mem_addr_o, ea);
                    end
                end
                pend_rd   = 1'b1;
                pend_addr = bus.mem_addr_o;
            end
        end
        if (ck && !cs && rst_n && bus.dq_oe_o === 1'b1 && bus.rwds_oe_o === 1'b1 && bus.rwds_o === 1'b1) begin
            took = 1'b1;
            checks++;
            if (exp_dat_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_data dq_o=%h", bus.dq_o);
            end else begin
                ed = exp_dat_q.pop_front();
                if (bus.dq_o !== ed) begin
                    errors++;
                    $display("FAIL read_data got %h want %h", bus.dq_o, ed);
                end
            end
        end
    endtask

    task automatic start_xfer(input logic [47:0] ca);
        logic [47:0] w;
        bit          took;
        w = ca;
        cycle(1'b0, 1'b0, 16'h0000, 2'b00, took);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, w[47:32], 2'b00, took);
            checks++;
            if ({bus.rwds_oe_o, bus.rwds_o} !== {1'b1, fix_m}) begin
                errors++;
                $display("FAIL ca_rwds word%0d got oe=%b rwds=%b want oe=1 rwds=%b", i, bus.rwds_oe_o, bus.rwds_o, fix_m);
            end
            w = w << 16;
        end
    endtask

    task automatic end_xfer();
        bit took;
        cycle(1'b1, 1'b0, 16'h0000, 2'b00, took);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_rd_q.size() != 0 || exp_dat_q.size() != 0 || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained left rd=%0d dat=%0d wr=%0d want 0/0/0",
                     name, exp_rd_q.size(), exp_dat_q.size(), exp_wr_q.size());
            exp_rd_q.delete();
            exp_dat_q.delete();
            exp_wr_q.delete();
        end
    endtask

    task automatic do_read(input bit rs, input bit lin, input logic [AW-1:0] start, input int n,
                           input bit close, output int lead, output int slots);
        logic [AW-1:0] a;
        int            got;
        bit            took;
        a = start;
        for (int k = 0; k < n; k++) begin
            if (rs) begin
                exp_dat_q.push_back(reg_model(a));
            end else begin
                exp_rd_q.push_back(a);
                exp_dat_q.push_back(mem[a[7:0]]);
            end
            a = nxt(a, lin);
        end
        // Every consumed slot fetches the following word, so the last slot prefetches one more.
        if (!rs) exp_rd_q.push_back(a);
        start_xfer(make_ca(1'b1, rs, lin, 32'(start)));
        got   = 0;
        lead  = -1;
        slots = 0;
        for (int c = 0; c < 64 && got < n; c++) begin
            cycle(1'b0, 1'b1, 16'h0000, 2'b00, took);
            slots++;
            if (took) begin
                if (lead < 0) lead = slots - 1;
                got++;
            end
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL read_timeout words=%0d want %0d", got, n);
        end
        if (close) end_xfer();
    endtask

    task automatic do_write(input logic [AW-1:0] start, input logic [15:0] d [2], input logic [1:0] m [2]);
        bit took;
        exp_wr_q.push_back('{start, d[0], ~m[0]});
        exp_wr_q.push_back('{nxt(start, 1'b1), d[1], ~m[1]});
        start_xfer(make_ca(1'b0, 1'b0, 1'b1, 32'(start)));
        for (int i = 0; i < lat_slots_m(); i++) cycle(1'b0, 1'b1, 16'hFFFF, 2'b00, took);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, d[i], m[i], took);
        end_xfer();
    endtask

    task automatic test_reset();
        bit took;
        rst_n = 1'b0;
        cycle(1'b1, 1'b0, 16'h0000, 2'b00, took);
        cycle(1'b1, 1'b0, 16'h0000, 2'b00, took);
        checks++;
        if ({bus.dq_oe_o, bus.rwds_oe_o, bus.rwds_o, bus.mem_req_o, bus.mem_we_o, bus.dq_o,
             bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got oe=%b/%b rwds=%b req=%b dq=%h want all 0",
                     bus.dq_oe_o, bus.rwds_oe_o, bus.rwds_o, bus.mem_req_o, bus.dq_o);
        end
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 16'h0000, 2'b00, took);
        checks++;
        if ({bus.dq_oe_o, bus.rwds_oe_o, bus.mem_req_o} !== 3'b000) begin
            errors++;
            $display("FAIL idle_outputs got %b want 000", {bus.dq_oe_o, bus.rwds_oe_o, bus.mem_req_o});
        end
    endtask

    task automatic test_read();
        int lead, slots;
        do_read(1'b0, 1'b1, 16'h0010, 4, 1'b1, lead, slots);
        checks++;
        if (lead != lat_slots_m()) begin
            errors++;
            $display("FAIL read_latency got %0d want %0d", lead, lat_slots_m());
        end
        checks++;
        if (slots != lead + 4) begin
            errors++;
            $display("FAIL read_stream got %0d slots want %0d", slots, lead + 4);
        end
        check_drained("read");
    endtask

    task automatic test_write();
        logic [15:0] d [2];
        logic [1:0]  m [2];
        int          lead, slots;
        d = '{16'hAAAA, 16'h5555};
        m = '{2'b00, 2'b10};
        do_write(16'h0020, d, m);
        check_drained("write");
        do_read(1'b0, 1'b1, 16'h0020, 2, 1'b1, lead, slots);
        check_drained("write_readback");
    endtask

    task automatic test_abort();
        int lead, slots;
        bit took;
        do_read(1'b0, 1'b1, 16'h0030, 2, 1'b0, lead, slots);
        cycle(1'b1, 1'b1, 16'h0000, 2'b00, took);
        checks++;
        if (bus.mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_req got %b want 0", bus.mem_req_o);
        end
        cycle(1'b1, 1'b0, 16'h0000, 2'b00, took);
        checks++;
        if ({bus.dq_oe_o, bus.rwds_oe_o, bus.mem_req_o} !== 3'b000) begin
            errors++;
            $display("FAIL abort_enables got %b want 000", {bus.dq_oe_o, bus.rwds_oe_o, bus.mem_req_o});
        end
        check_drained("abort");
    endtask

    task automatic test_wrap();
        int lead, slots;
        do_read(1'b0, 1'b0, 16'h001E, 4, 1'b1, lead, slots);
        check_drained("wrap");
    endtask

    task automatic test_reg_cfg();
        int lead, slots;
        bit took;
        start_xfer(make_ca(1'b0, 1'b1, 1'b1, 32'h0));
        cycle(1'b0, 1'b1, 16'h0040, 2'b00, took);
        cycle(1'b0, 1'b1, 16'h00F8, 2'b00, took);
        end_xfer();
        lat_m = 4'd4;
        fix_m = 1'b0;
        do_read(1'b0, 1'b1, 16'h0008, 2, 1'b1, lead, slots);
        checks++;
        if (lead != 4) begin
            errors++;
            $display("FAIL cfg_latency got %0d want 4", lead);
        end
        do_read(1'b1, 1'b1, 16'h0000, 2, 1'b1, lead, slots);
        check_drained("reg_cfg");
    endtask

    task automatic test_reset_mid_write();
        int lead, slots;
        bit took;
        exp_wr_q.push_back('{16'h0050, 16'h1234, 2'b11});
        start_xfer(make_ca(1'b0, 1'b0, 1'b1, 32'h50));
        for (int i = 0; i < lat_slots_m(); i++) cycle(1'b0, 1'b1, 16'hFFFF, 2'b00, took);
        cycle(1'b0, 1'b1, 16'h1234, 2'b00, took);
        rst_n = 1'b0;
        cycle(1'b0, 1'b1, 16'h9999, 2'b00, took);
        checks++;
        if (bus.mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_write_req got %b want 0", bus.mem_req_o);
        end
        rst_n = 1'b1;
        end_xfer();
        lat_m = 4'd6;
        fix_m = 1'b1;
        do_read(1'b1, 1'b1, 16'h0000, 1, 1'b1, lead, slots);
        checks++;
        if (lead != 12) begin
            errors++;
            $display("FAIL reset_cr0_latency got %0d want 12", lead);
        end
        check_drained("reset_mid_write");
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.cs_ni       = 1'b1;
        bus.ck_en_i     = 1'b0;
        bus.dq_i        = '0;
        bus.rwds_i      = '0;
        bus.mem_rdata_i = '0;
        for (int i = 0; i < 256; i++) mem[i] = {8'(i), ~8'(i)};
        test_reset();
        test_read();
        test_write();
        test_abort();
        test_wrap();
        test_reg_cfg();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hyper_dev_resp.md
HYPER_DEV_RESP -- requirements
Module: hyper_dev_resp

Interface
REQ-001 SHALL have parameter AddrWidth, default 16, meaning internal word-address bits driven on mem_addr_o.
REQ-002 SHALL have parameter RstLatency, default 6, meaning reset value of CR0 latency field (word slots).
REQ-003 SHALL have one clock and a synchronous, active-low reset: clk_i  in  1  sole clock, all logic on rising edge.
REQ-004 rst_ni  in  1  synchronous active-low reset.
REQ-005 cs_ni  in  1  bus chip select, active low.
REQ-006 ck_en_i  in  1  bus word slot; one 16-bit word transferred per cycle with ck_en_i=1.
REQ-007 dq_i  in  16  word from controller (CA or write data).
REQ-008 rwds_i  in  2  write byte mask per byte; 1 = byte masked.
REQ-009 dq_o  out  16  read word; dq_oe_o  out  1  dq drive enable.
REQ-010 rwds_o  out  1  strobe / latency indicator; rwds_oe_o  out  1  rwds drive enable.
REQ-011 mem_req_o  out  1, mem_we_o  out  1, mem_addr_o  out  AddrWidth, mem_wdata_o  out  16, mem_be_o  out  2: memory port, 1-cycle request.
REQ-012 mem_rdata_i  in  16  read data, valid exactly one cycle after a read request.

Function
REQ-013 FSM states SHALL be Idle, CmdAddr, Latency, Read, Write, RegWrite, Done.
REQ-014 Any cycle with cs_ni=1 SHALL force Idle next cycle, cancel the transfer, and ignore any ck_en_i that cycle.
REQ-015 Idle -> CmdAddr on cs_ni=0; CmdAddr captures three ck_en_i words into CA[47:32], CA[31:16], CA[15:0].
REQ-016 Decode: CA[47]=1 read, 0 write; CA[46]=1 register space; CA[45]=1 linear, 0 wrapped; word address = {CA[44:16],CA[2:0]}, low AddrWidth bits used.
REQ-017 During CmdAddr, rwds_oe_o=1 and rwds_o=CR0.fixed2x.
REQ-018 Latency slots L = CR0.lat * (CR0.fixed2x ? 2 : 1); counter of 5 bits, decremented per ck_en_i slot; L=0 SHALL skip Latency.
REQ-019 Register-space write SHALL go CmdAddr -> RegWrite with zero latency; first data word writes CR0 ([7:4] lat, [3] fixed2x); later words ignored -> Done.
REQ-020 Memory read: on final Latency slot issue mem read of start address; next cycle register mem_rdata_i into dq_q and enter Read.
REQ-021 In Read: dq_oe_o=1, dq_o=dq_q, rwds_oe_o=1, rwds_o=1 while dq_q valid; each ck_en_i slot consumes dq_q and issues read of next address in the same cycle, so back-to-back slots stream one word per cycle.
REQ-022 Register-space read SHALL return CR0 zero-extended at address 0, constant 16'h0C81 at other addresses, no mem requests.
REQ-023 In Write: each ck_en_i slot issues mem_req_o=1, mem_we_o=1, mem_wdata_o=dq_i, mem_be_o=~rwds_i, then increments address.
REQ-024 Linear address increment SHALL wrap modulo 2^AddrWidth.
REQ-025 Done holds all enables low until cs_ni=1.
REQ-026 Outside Read/CmdAddr, dq_oe_o=0 and rwds_oe_o=0; mem_req_o=0 outside issuing cycles.

Reset
REQ-027 On rst_ni=0 at a clock edge: state Idle, CR0.lat=RstLatency, CR0.fixed2x=1, all outputs 0, dq_q=0.
REQ-028 Reset mid-transfer SHALL abort without issuing further mem requests.

Configuration
REQ-029 Macro HYPER_DEV_RESP_WRAP_EN defined: wrapped bursts (CA[45]=0) increment only address[3:0] modulo 16, upper bits fixed.
REQ-030 Macro undefined: CA[45] ignored; all bursts linear per REQ-024.

Verification
REQ-031 Reset, CA read addr 0x10, 12 latency slots, 4 slots -> rwds_o=1 during CA; mem reads 0x10..0x13; dq_o equals preloaded words in order.
REQ-032 Write addr 0x20, data 0xAAAA/0x5555, rwds_i=2'b00/2'b10 -> mem writes be=2'b11 at 0x20, be=2'b01 at 0x21.
REQ-033 Register write 0x0040 (lat=4, fixed2x=0), then memory read -> rwds_o=0 during CA, first data after 4 latency slots.
REQ-034 With HYPER_DEV_RESP_WRAP_EN, wrapped read start 0x1E, 4 slots -> addresses 0x1E,0x1F,0x10,0x11; without macro -> 0x1E..0x21.
REQ-035 cs_ni raised after second read word, simultaneous with ck_en_i -> no further mem_req_o, enables 0 next cycle, Idle.
REQ-036 rst_ni=0 during Write burst -> no write that cycle onward; CR0 back to lat=6, fixed2x=1.
